// File: rtl/sram_bridge.sv
// sram_bridge
//   Bridges an asynchronous AVR external-memory strobe pair onto a
//   single-port asynchronous SRAM. Both AVR strobes are resynchronised to
//   clk. A small FSM (IDLE/SETUP/WR/RD/RECOVER) then runs one timed SRAM
//   cycle per AVR access. An optional auto-increment address counter
//   supports burst transfers without the AVR driving every address.
//
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   avr_we_n, avr_oe_n    : AVR write/read strobes (async, active-low)
//   avr_addr, avr_din     : AVR address and write data
//   avr_dout, avr_dout_oe : read data back to the AVR and its pad enable
//   auto_inc, addr_load   : counter mode select, counter load pulse
//   sram_addr             : SRAM address
//   sram_din              : SRAM read data
//   sram_dout, sram_dout_oe : SRAM write data and its pad enable
//   sram_ce_n/we_n/oe_n   : SRAM controls, active-low
//   busy                  : FSM is not idle
//   err                   : sticky strobe-collision flag
module sram_bridge #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 19,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avr_we_n,
  input  logic              avr_oe_n,
  input  logic [AWIDTH-1:0] avr_addr,
  input  logic [DWIDTH-1:0] avr_din,
  output logic [DWIDTH-1:0] avr_dout,
  output logic              avr_dout_oe,
  input  logic              auto_inc,
  input  logic              addr_load,
  output logic [AWIDTH-1:0] sram_addr,
  input  logic [DWIDTH-1:0] sram_din,
  output logic [DWIDTH-1:0] sram_dout,
  output logic              sram_dout_oe,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WR,
    S_RD,
    S_RECOVER
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT);

  state_t            state;
  logic              dir_wr;
  logic [3:0]        wait_cnt;
  logic [AWIDTH-1:0] addr_cnt;
  logic [AWIDTH-1:0] acc_addr;

  // Two-flop synchronisers; idle level is high (strobes released).
  logic we_p0, we_s;
  logic oe_p0, oe_s;

  // A load coinciding with an access start must win over the stale count.
  always_comb begin
    acc_addr = avr_addr;
    if (auto_inc && !addr_load)
      acc_addr = addr_cnt;
  end

  // sram_dout doubles as the write buffer and avr_dout as the read buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_p0        <= 1'b1;
      we_s         <= 1'b1;
      oe_p0        <= 1'b1;
      oe_s         <= 1'b1;
      state        <= S_IDLE;
      dir_wr       <= 1'b0;
      wait_cnt     <= '0;
      addr_cnt     <= '0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      avr_dout     <= '0;
      sram_ce_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_dout_oe <= 1'b0;
      avr_dout_oe  <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // synchroniser stage p0 -> s
      we_p0 <= avr_we_n;
      we_s  <= we_p0;
      oe_p0 <= avr_oe_n;
      oe_s  <= oe_p0;

      case (state)
        S_IDLE: begin
          if (addr_load)
            addr_cnt <= avr_addr;
          if (!we_s && !oe_s) begin
            err <= 1'b1;
          end else if (!we_s || !oe_s) begin
            dir_wr    <= !we_s;
            sram_addr <= acc_addr;
            if (!we_s) begin
              sram_dout    <= avr_din;
              sram_dout_oe <= 1'b1;
            end
            sram_ce_n <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SETUP;
          end
        end

        S_SETUP: begin
          wait_cnt <= '0;
          if (dir_wr) begin
            sram_we_n <= 1'b0;
            state     <= S_WR;
          end else begin
            sram_oe_n <= 1'b0;
            state     <= S_RD;
          end
        end

        // Chip enable and data stay driven into the first RECOVER cycle
        // to give the SRAM hold time after the write strobe rises.
        S_WR: begin
          if (wait_cnt == WAIT_LAST) begin
            sram_we_n <= 1'b1;
            state     <= S_RECOVER;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        S_RD: begin
          if (wait_cnt == WAIT_LAST) begin
            avr_dout    <= sram_din;
            avr_dout_oe <= !oe_s;
            sram_oe_n   <= 1'b1;
            sram_ce_n   <= 1'b1;
            state       <= S_RECOVER;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        S_RECOVER: begin
          sram_ce_n    <= 1'b1;
          sram_dout_oe <= 1'b0;
          if (we_s && oe_s) begin
            avr_dout_oe <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
            if (auto_inc)
              addr_cnt <= addr_cnt + 1'b1;
          end else begin
            avr_dout_oe <= !dir_wr && !oe_s;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
module tb_sram_bridge;
  localparam int DW = 8;
  localparam int AW = 19;
  localparam int WT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          avr_we_n = 1'b1;
  logic          avr_oe_n = 1'b1;
  logic [AW-1:0] avr_addr = '0;
  logic [DW-1:0] avr_din = '0;
  logic [DW-1:0] avr_dout;
  logic          avr_dout_oe;
  logic          auto_inc = 1'b0;
  logic          addr_load = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic          sram_dout_oe;
  logic          sram_ce_n;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          busy;
  logic          err;

  logic [DW-1:0] rd_val = 8'h3C;

  sram_bridge #(.DWIDTH(DW), .AWIDTH(AW), .WAIT(WT)) dut (
    .clk(clk), .reset(reset),
    .avr_we_n(avr_we_n), .avr_oe_n(avr_oe_n),
    .avr_addr(avr_addr), .avr_din(avr_din),
    .avr_dout(avr_dout), .avr_dout_oe(avr_dout_oe),
    .auto_inc(auto_inc), .addr_load(addr_load),
    .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_dout_oe(sram_dout_oe),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the read value only while actually being read.
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? rd_val : 8'hEE;

  int total = 0;
  int bad = 0;

  int            we_lo, oe_lo, ce_lo, doe_lo, dout_bad, overlap;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          prev_we, prev_oe;
  logic [DW-1:0] exp_dout;

  task automatic clear_mon();
    we_lo = 0; oe_lo = 0; ce_lo = 0; doe_lo = 0; dout_bad = 0; overlap = 0;
    wr_addr = '1; rd_addr = '1; prev_we = 1'b1; prev_oe = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!sram_we_n) we_lo++;
    if (!sram_oe_n) oe_lo++;
    if (!sram_ce_n) ce_lo++;
    if (sram_dout_oe) doe_lo++;
    if (sram_dout_oe && sram_dout !== exp_dout) dout_bad++;
    if (!sram_we_n && !sram_oe_n) overlap++;
    if (sram_dout_oe && !sram_oe_n) overlap++;
    if (!sram_we_n && prev_we) wr_addr = sram_addr;
    if (!sram_oe_n && prev_oe) rd_addr = sram_addr;
    prev_we = sram_we_n;
    prev_oe = sram_oe_n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    clear_mon();
    avr_addr = a;
    avr_din  = d;
    exp_dout = d;
    avr_we_n = 1'b0;
    repeat (8) step();
    avr_we_n = 1'b1;
    wait_idle("wr");
  endtask

  initial begin
    clear_mon();
    exp_dout = '0;
    #2 reset = 1'b0;
    repeat (2) step();
    check("rst_ctl", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
    check("rst_oe_busy_err", {28'd0, sram_dout_oe, avr_dout_oe, busy, err}, 32'h0);
    check("rst_data", {5'd0, sram_addr, sram_dout}, 32'h0);
    check("rst_avr_dout", {24'd0, avr_dout}, 32'h0);
    @(negedge clk) reset = 1'b1;

    // Single write
    clear_mon();
    auto_inc = 1'b0;
    avr_addr = 19'h00123;
    avr_din  = 8'hA5;
    exp_dout = 8'hA5;
    avr_we_n = 1'b0;
    repeat (10) step();
    avr_we_n = 1'b1;
    wait_idle("write");
    check("write_addr", {13'd0, wr_addr}, 32'h00123);
    check("write_we_cycles", we_lo, 3);
    check("write_dout_oe_cycles", doe_lo, 5);
    check("write_ce_cycles", ce_lo, 5);
    check("write_dout_value", dout_bad, 0);
    check("write_no_oe", oe_lo, 0);
    check("write_overlap", overlap, 0);

    // Single read
    clear_mon();
    avr_addr = 19'h00456;
    avr_oe_n = 1'b0;
    repeat (10) step();
    check("read_avr_dout", {24'd0, avr_dout}, 32'h3C);
    check("read_avr_dout_oe", {31'd0, avr_dout_oe}, 32'd1);
    avr_oe_n = 1'b1;
    wait_idle("read");
    check("read_oe_cycles", oe_lo, 3);
    check("read_addr", {13'd0, rd_addr}, 32'h00456);
    check("read_no_we", we_lo, 0);
    check("read_no_dout_oe", doe_lo, 0);
    check("read_oe_released", {31'd0, avr_dout_oe}, 32'd0);
    check("read_overlap", overlap, 0);

    // Burst with wrap
    auto_inc  = 1'b1;
    avr_addr  = 19'h7FFFE;
    addr_load = 1'b1;
    step();
    addr_load = 1'b0;
    do_write(19'h00000, 8'h11);
    check("burst_addr0", {13'd0, wr_addr}, 32'h7FFFE);
    check("burst_we0", we_lo, 3);
    do_write(19'h00000, 8'h22);
    check("burst_addr1", {13'd0, wr_addr}, 32'h7FFFF);
    check("burst_data1", dout_bad, 0);
    do_write(19'h12345, 8'h33);
    check("burst_addr2_wrap", {13'd0, wr_addr}, 32'h00000);

    // addr_load during RD is ignored; counter was 1 after the wrap
    clear_mon();
    rd_val   = 8'h96;
    avr_addr = 19'h05555;
    avr_oe_n = 1'b0;
    repeat (4) step();
    check("rdload_in_rd", {31'd0, sram_oe_n}, 32'd0);
    avr_addr  = 19'h11111;
    addr_load = 1'b1;
    step();
    addr_load = 1'b0;
    avr_addr  = 19'h22222;
    repeat (5) step();
    check("rdload_data", {24'd0, avr_dout}, 32'h96);
    avr_oe_n = 1'b1;
    wait_idle("rdload");
    check("rdload_rd_addr", {13'd0, rd_addr}, 32'h00001);
    do_write(19'h33333, 8'h44);
    check("rdload_next_addr", {13'd0, wr_addr}, 32'h00002);

    // Strobe collision
    clear_mon();
    auto_inc = 1'b0;
    avr_we_n = 1'b0;
    avr_oe_n = 1'b0;
    repeat (6) step();
    check("coll_err", {31'd0, err}, 32'd1);
    check("coll_busy", {31'd0, busy}, 32'd0);
    avr_we_n = 1'b1;
    avr_oe_n = 1'b1;
    repeat (4) step();
    check("coll_err_sticky", {31'd0, err}, 32'd1);
    check("coll_no_strobe", ce_lo + we_lo + oe_lo, 0);

    // Reset in the second WR cycle
    clear_mon();
    avr_addr = 19'h00ABC;
    avr_din  = 8'hC3;
    exp_dout = 8'hC3;
    avr_we_n = 1'b0;
    repeat (5) step();
    check("midrst_in_wr", {31'd0, sram_we_n}, 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_ctl", {29'd0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
    check("midrst_oe_busy_err", {28'd0, sram_dout_oe, avr_dout_oe, busy, err}, 32'h0);
    avr_we_n = 1'b1;
    repeat (2) step();
    @(negedge clk) reset = 1'b1;
    clear_mon();
    repeat (4) step();
    check("midrst_no_glitch", ce_lo + we_lo + oe_lo, 0);
    do_write(19'h00777, 8'h5A);
    check("postrst_addr", {13'd0, wr_addr}, 32'h00777);
    check("postrst_we", we_lo, 3);
    check("postrst_data", dout_bad, 0);

    // addr_load coinciding with access start supplies the address
    clear_mon();
    auto_inc = 1'b1;
    avr_addr = 19'h00999;
    avr_din  = 8'h77;
    exp_dout = 8'h77;
    avr_we_n = 1'b0;
    repeat (2) step();
    avr_addr  = 19'h40000;
    addr_load = 1'b1;
    step();
    addr_load = 1'b0;
    avr_addr  = 19'h00999;
    repeat (7) step();
    avr_we_n = 1'b1;
    wait_idle("ldstart");
    check("ldstart_addr", {13'd0, wr_addr}, 32'h40000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
